// File: rtl/orchestrator_pkg.sv
// Shared decode constants, FSM state type and instruction-class helpers
// for the decode-stage hazard orchestrator.
package orchestrator_pkg;

   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

   localparam logic [31:0] INVALID_INST = 32'h0000_0000;
   localparam logic [31:0] HALT_INST    = 32'hC000_1073;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   function automatic logic reads_rs1(input logic [6:0] opcode);
      return (opcode == OPCODE_OP) || (opcode == OPCODE_OP_IMM) ||
             (opcode == OPCODE_BRANCH) || (opcode == OPCODE_STORE) ||
             (opcode == OPCODE_LOAD) || (opcode == OPCODE_JALR);
   endfunction

   function automatic logic reads_rs2(input logic [6:0] opcode);
      return (opcode == OPCODE_OP) || (opcode == OPCODE_BRANCH) ||
             (opcode == OPCODE_STORE);
   endfunction

   function automatic logic writes_rd(input logic [6:0] opcode);
      return (opcode == OPCODE_OP) || (opcode == OPCODE_OP_IMM) ||
             (opcode == OPCODE_LUI) || (opcode == OPCODE_AUIPC) ||
             (opcode == OPCODE_JAL) || (opcode == OPCODE_JALR) ||
             (opcode == OPCODE_LOAD);
   endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard: a nonzero count marks a register
// whose in-flight result is not yet readable.
module hazard_scoreboard #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set_i,
   input  logic [4:0]       rd_i,
   input  logic [CNT_W-1:0] len_i,
   input  logic [4:0]       rs1_i,
   input  logic [4:0]       rs2_i,
   output logic             rs1_busy_o,
   output logic             rs2_busy_o,
   output logic             all_clear_o
);

   logic [CNT_W-1:0] busy_q [1:31];
   logic [CNT_W-1:0] busy_d [1:31];
   logic [31:0]      nz;

   // A fresh load on the same register overrides that cycle's decrement.
   always_comb begin
      nz = '0;
      for (int r = 1; r < 32; r++) begin
         nz[r]     = (busy_q[r] != '0);
         busy_d[r] = busy_q[r];
         if (set_i && (rd_i == 5'(r))) begin
            busy_d[r] = len_i;
         end else if (nz[r]) begin
            busy_d[r] = busy_q[r] - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 1; r < 32; r++) begin
            busy_q[r] <= '0;
         end
      end else begin
         busy_q <= busy_d;
      end
   end

   assign rs1_busy_o  = nz[rs1_i];
   assign rs2_busy_o  = nz[rs2_i];
   assign all_clear_o = ~|nz;

endmodule

// File: rtl/hazard_orchestrator.sv
// Decode-stage hazard unit: RAW scoreboard stalls, control bubbles after
// branches/jumps, and a counted halt drain that waits for the scoreboard.
module hazard_orchestrator
   import orchestrator_pkg::*;
#(
   parameter int INST_WIDTH_IN_BIT = 32,
   parameter int WB_DEPTH          = 2,
   parameter int LOAD_EXTRA        = 0,
   parameter int CTRL_BUBBLES      = 2,
   parameter int HALT_DRAIN        = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         inst_valid,
   input  logic [INST_WIDTH_IN_BIT-1:0] next_inst,
   input  logic                         flush,
   output logic                         issue,
   output logic                         stall_id_if_pl,
   output logic                         stall_pc_increment,
   output logic                         halt,
   output logic [1:0]                   state
);

   localparam int               CNT_W      = $clog2(WB_DEPTH + LOAD_EXTRA + 1);
   localparam logic [CNT_W-1:0] LEN_ALU    = CNT_W'(WB_DEPTH);
   localparam logic [CNT_W-1:0] LEN_LOAD   = CNT_W'(WB_DEPTH + LOAD_EXTRA);
   localparam logic [2:0]       CTRL_LOAD  = 3'(CTRL_BUBBLES);
   localparam logic [2:0]       DRAIN_LOAD = 3'(HALT_DRAIN);

   state_e     state_q, state_d;
   logic [2:0] ctrl_q, ctrl_d;
   logic [2:0] drain_q, drain_d;

   logic [INST_WIDTH_IN_BIT-1:0] inst_eff;
   logic [6:0]                   op;
   logic [4:0]                   rd, rs1, rs2;
   logic is_halt, is_ctrl, rs1_busy, rs2_busy, all_clear;
   logic raw_hazard, ctrl_busy, stall, sb_set;
   logic [CNT_W-1:0] sb_len;

   // Invalid slots decode as an opcode with no class, so they never set or read.
   assign inst_eff = inst_valid ? next_inst : INST_WIDTH_IN_BIT'(INVALID_INST);
   assign op       = inst_eff[6:0];
   assign rd       = inst_eff[11:7];
   assign rs1      = inst_eff[19:15];
   assign rs2      = inst_eff[24:20];
   assign is_halt  = (inst_eff == INST_WIDTH_IN_BIT'(HALT_INST));
   assign is_ctrl  = (op == OPCODE_BRANCH) || (op == OPCODE_JAL) || (op == OPCODE_JALR);

   assign raw_hazard = inst_valid & ((reads_rs1(op) & rs1_busy) | (reads_rs2(op) & rs2_busy));
   // A redirect cancels the remaining bubbles in the same cycle it arrives.
   assign ctrl_busy  = (ctrl_q != 3'd0) & ~flush;
   assign stall      = (state_q != ST_RUN) | ctrl_busy | raw_hazard;
   assign issue      = inst_valid & ~stall & ~flush & ~reset;

   assign sb_set = issue & writes_rd(op) & (rd != 5'd0) & ~is_halt;
   assign sb_len = (op == OPCODE_LOAD) ? LEN_LOAD : LEN_ALU;

   hazard_scoreboard #(.CNT_W(CNT_W)) u_scoreboard (
      .clk         (clk),
      .reset       (reset),
      .set_i       (sb_set),
      .rd_i        (rd),
      .len_i       (sb_len),
      .rs1_i       (rs1),
      .rs2_i       (rs2),
      .rs1_busy_o  (rs1_busy),
      .rs2_busy_o  (rs2_busy),
      .all_clear_o (all_clear)
   );

   always_comb begin
      ctrl_d = ctrl_q;
      if (flush) begin
         ctrl_d = 3'd0;
      end else if (issue && is_ctrl) begin
         ctrl_d = CTRL_LOAD;
      end else if (ctrl_q != 3'd0) begin
         ctrl_d = ctrl_q - 3'd1;
      end
   end

   // Leaving DRAIN as the count expires lets halt rise HALT_DRAIN+1 cycles after issue.
   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      case (state_q)
         ST_RUN: begin
            if (issue && is_halt) begin
               state_d = ST_DRAIN;
               drain_d = DRAIN_LOAD;
            end
         end
         ST_DRAIN: begin
            if (drain_q != 3'd0) drain_d = drain_q - 3'd1;
            if ((drain_q <= 3'd1) && all_clear) state_d = ST_HALTED;
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
         ctrl_q  <= 3'd0;
         drain_q <= 3'd0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         drain_q <= drain_d;
      end
   end

   assign stall_id_if_pl     = stall;
   assign stall_pc_increment = stall;
   assign halt               = (state_q == ST_HALTED);
   assign state              = state_q;

endmodule

// File: tb/tb_hazard_orchestrator.sv
// Self-checking bench for hazard_orchestrator: a deadline-based reference
// model (cycle at which each register becomes readable) checks every cycle.
module tb_hazard_orchestrator;

   localparam int WB = 2;
   localparam int LE = 2;
   localparam int CB = 2;
   localparam int HD = 2;
   localparam logic [31:0] HALT = 32'hC000_1073;

   localparam logic [6:0] O_LOAD = 7'h03, O_IMM = 7'h13, O_AUIPC = 7'h17, O_STORE = 7'h23,
                          O_OP = 7'h33, O_LUI = 7'h37, O_BR = 7'h63, O_JALR = 7'h67, O_JAL = 7'h6F;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        inst_valid = 1'b0;
   logic [31:0] next_inst = 32'h0;
   logic        flush = 1'b0;
   logic        issue, stall_id_if_pl, stall_pc_increment, halt;
   logic [1:0]  state;

   int n_cmp = 0;
   int n_bad = 0;

   int cyc = 0;
   int ready [32];
   int ctrl_end = -1;
   int halt_iss = -1;
   int halted_from = 1 << 30;
   logic got_issue, got_halt;

   hazard_orchestrator #(
      .INST_WIDTH_IN_BIT(32), .WB_DEPTH(WB), .LOAD_EXTRA(LE),
      .CTRL_BUBBLES(CB), .HALT_DRAIN(HD)
   ) dut (
      .clk(clk), .reset(reset), .inst_valid(inst_valid), .next_inst(next_inst),
      .flush(flush), .issue(issue), .stall_id_if_pl(stall_id_if_pl),
      .stall_pc_increment(stall_pc_increment), .halt(halt), .state(state)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b010, rd, op};
   endfunction

   function automatic bit m_r1(input logic [6:0] op);
      return op inside {O_OP, O_IMM, O_BR, O_STORE, O_LOAD, O_JALR};
   endfunction
   function automatic bit m_r2(input logic [6:0] op);
      return op inside {O_OP, O_BR, O_STORE};
   endfunction
   function automatic bit m_wr(input logic [6:0] op);
      return op inside {O_OP, O_IMM, O_LUI, O_AUIPC, O_JAL, O_JALR, O_LOAD};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) ready[i] = 0;
      ctrl_end = -1;
      halt_iss = -1;
      halted_from = 1 << 30;
   endtask

   // One clock cycle: drive, predict, compare, update model, advance.
   task automatic step(input logic v, input logic [31:0] ins, input logic fl);
      logic [6:0] op;
      logic [4:0] rd, r1, r2;
      logic [1:0] e_state;
      bit raw, cact, e_stall, e_issue, e_halt;
      int maxr;
      inst_valid = v; next_inst = ins; flush = fl;
      op = ins[6:0]; rd = ins[11:7]; r1 = ins[19:15]; r2 = ins[24:20];
      if (halt_iss < 0 || cyc <= halt_iss) e_state = 2'd0;
      else if (cyc < halted_from) e_state = 2'd1;
      else e_state = 2'd2;
      e_halt = (e_state == 2'd2);
      cact = (cyc <= ctrl_end) && !fl;
      raw = v && ((m_r1(op) && r1 != 5'd0 && ready[r1] > cyc) ||
                  (m_r2(op) && r2 != 5'd0 && ready[r2] > cyc));
      e_stall = (e_state != 2'd0) || cact || raw;
      e_issue = v && !e_stall && !fl;
      #3;
      n_cmp++; if (issue !== e_issue) begin n_bad++; $display("FAIL issue cyc=%0d got=%b exp=%b", cyc, issue, e_issue); end
      n_cmp++; if (stall_id_if_pl !== e_stall) begin n_bad++; $display("FAIL stall cyc=%0d got=%b exp=%b", cyc, stall_id_if_pl, e_stall); end
      n_cmp++; if (stall_pc_increment !== e_stall) begin n_bad++; $display("FAIL stall_pc cyc=%0d got=%b exp=%b", cyc, stall_pc_increment, e_stall); end
      n_cmp++; if (halt !== e_halt) begin n_bad++; $display("FAIL halt cyc=%0d got=%b exp=%b", cyc, halt, e_halt); end
      n_cmp++; if (state !== e_state) begin n_bad++; $display("FAIL state cyc=%0d got=%0d exp=%0d", cyc, state, e_state); end
      got_issue = issue;
      got_halt = halt;
      if (e_issue) begin
         if (ins == HALT) begin
            maxr = 0;
            for (int i = 0; i < 32; i++) if (ready[i] > maxr) maxr = ready[i];
            halt_iss = cyc;
            halted_from = (((cyc + HD) > maxr) ? (cyc + HD) : maxr) + 1;
         end else begin
            if (m_wr(op) && rd != 5'd0) ready[rd] = cyc + WB + ((op == O_LOAD) ? LE : 0) + 1;
            if (op inside {O_BR, O_JAL, O_JALR}) ctrl_end = cyc + CB;
         end
      end
      if (fl && ctrl_end >= cyc) ctrl_end = cyc - 1;
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0);
   endtask

   task automatic do_reset();
      inst_valid = 1'b0; flush = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_clear();
      cyc++;
   endtask

   // Present ins until it issues; returns the number of stalled cycles.
   task automatic stalls_until_issue(input logic [31:0] ins, output int n);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         step(1'b1, ins, 1'b0);
         if (got_issue === 1'b1) return;
         n++;
      end
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout got=no_issue exp=issue_within_20");
   endtask

   task automatic test_reset();
      inst_valid = 1'b1; next_inst = enc(O_OP, 5'd6, 5'd5, 5'd5); flush = 1'b0;
      #4;
      n_cmp++; if (issue !== 1'b0) begin n_bad++; $display("FAIL rst_issue got=%b exp=0", issue); end
      n_cmp++; if (stall_id_if_pl !== 1'b0) begin n_bad++; $display("FAIL rst_stall got=%b exp=0", stall_id_if_pl); end
      n_cmp++; if (halt !== 1'b0) begin n_bad++; $display("FAIL rst_halt got=%b exp=0", halt); end
      n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL rst_state got=%0d exp=0", state); end
      @(posedge clk); #1;
      reset = 1'b0;
      model_clear();
      cyc = 0;
   endtask

   task automatic test_raw_default();
      int n;
      step(1'b1, enc(O_IMM, 5'd5, 5'd0, 5'd0), 1'b0);
      stalls_until_issue(enc(O_OP, 5'd6, 5'd5, 5'd5), n);
      n_cmp++; if (n != WB) begin n_bad++; $display("FAIL raw_stalls got=%0d exp=%0d", n, WB); end
   endtask

   task automatic test_load();
      int n;
      idle(6);
      step(1'b1, enc(O_LOAD, 5'd7, 5'd1, 5'd0), 1'b0);
      stalls_until_issue(enc(O_IMM, 5'd8, 5'd7, 5'd0), n);
      n_cmp++; if (n != WB + LE) begin n_bad++; $display("FAIL load_stalls got=%0d exp=%0d", n, WB + LE); end
      step(1'b1, enc(O_LOAD, 5'd0, 5'd1, 5'd0), 1'b0);
      stalls_until_issue(enc(O_IMM, 5'd9, 5'd0, 5'd0), n);
      n_cmp++; if (n != 0) begin n_bad++; $display("FAIL load_x0_stalls got=%0d exp=0", n); end
   endtask

   task automatic test_ctrl_flush();
      int n;
      idle(6);
      step(1'b1, enc(O_BR, 5'd0, 5'd1, 5'd2), 1'b0);
      stalls_until_issue(enc(O_OP, 5'd10, 5'd11, 5'd12), n);
      n_cmp++; if (n != CB) begin n_bad++; $display("FAIL br_stalls got=%0d exp=%0d", n, CB); end
      idle(3);
      step(1'b1, enc(O_BR, 5'd0, 5'd1, 5'd2), 1'b0);
      step(1'b1, enc(O_OP, 5'd10, 5'd11, 5'd12), 1'b1);
      n_cmp++; if (got_issue !== 1'b0) begin n_bad++; $display("FAIL flush_issue got=%b exp=0", got_issue); end
      step(1'b1, enc(O_OP, 5'd10, 5'd11, 5'd12), 1'b0);
      n_cmp++; if (got_issue !== 1'b1) begin n_bad++; $display("FAIL post_flush_issue got=%b exp=1", got_issue); end
   endtask

   task automatic test_store_rs2();
      int n;
      idle(6);
      step(1'b1, enc(O_LUI, 5'd3, 5'd17, 5'd9), 1'b0);
      step(1'b1, enc(O_STORE, 5'd0, 5'd2, 5'd9), 1'b0);
      n_cmp++; if (got_issue !== 1'b1) begin n_bad++; $display("FAIL sw_indep_issue got=%b exp=1", got_issue); end
      stalls_until_issue(enc(O_STORE, 5'd0, 5'd2, 5'd3), n);
      n_cmp++; if (n != WB - 1) begin n_bad++; $display("FAIL sw_rs2_stalls got=%0d exp=%0d", n, WB - 1); end
   endtask

   task automatic test_random();
      logic [6:0] ops [9] = '{O_LOAD, O_IMM, O_AUIPC, O_STORE, O_OP, O_LUI, O_BR, O_JALR, O_JAL};
      for (int i = 0; i < 400; i++) begin
         step(logic'($urandom_range(0, 9) != 0),
              enc(ops[$urandom_range(0, 8)], 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))),
              logic'($urandom_range(0, 15) == 0));
      end
   endtask

   task automatic halt_wait(input int exp, input string tag);
      int k;
      k = 0;
      for (int i = 1; i <= 30; i++) begin
         step(1'b1, enc(O_OP, 5'd4, 5'd0, 5'd0), 1'b0);
         if (got_halt === 1'b1) begin k = i; break; end
      end
      n_cmp++; if (k != exp) begin n_bad++; $display("FAIL %s got=%0d exp=%0d", tag, k, exp); end
   endtask

   task automatic test_halt_empty();
      idle(8);
      step(1'b1, HALT, 1'b0);
      n_cmp++; if (got_issue !== 1'b1) begin n_bad++; $display("FAIL halt_issue got=%b exp=1", got_issue); end
      halt_wait(HD + 1, "halt_empty_latency");
      idle(3);
   endtask

   task automatic test_halt_load();
      do_reset();
      step(1'b1, enc(O_LOAD, 5'd7, 5'd1, 5'd0), 1'b0);
      step(1'b1, HALT, 1'b0);
      halt_wait(WB + LE + 1, "halt_load_latency");
   endtask

   task automatic test_reset_mid_drain();
      do_reset();
      step(1'b1, enc(O_LOAD, 5'd7, 5'd1, 5'd0), 1'b0);
      step(1'b1, HALT, 1'b0);
      step(1'b0, 32'h0, 1'b0);
      inst_valid = 1'b1; next_inst = enc(O_OP, 5'd6, 5'd7, 5'd7); flush = 1'b0;
      #1 reset = 1'b1;
      #1;
      n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL mid_rst_state got=%0d exp=0", state); end
      n_cmp++; if (halt !== 1'b0) begin n_bad++; $display("FAIL mid_rst_halt got=%b exp=0", halt); end
      n_cmp++; if (stall_id_if_pl !== 1'b0) begin n_bad++; $display("FAIL mid_rst_stall got=%b exp=0", stall_id_if_pl); end
      n_cmp++; if (issue !== 1'b0) begin n_bad++; $display("FAIL mid_rst_issue got=%b exp=0", issue); end
      @(posedge clk); #1;
      reset = 1'b0;
      model_clear();
      cyc++;
      step(1'b1, enc(O_OP, 5'd6, 5'd7, 5'd7), 1'b0);
      n_cmp++; if (got_issue !== 1'b1) begin n_bad++; $display("FAIL post_rst_issue got=%b exp=1", got_issue); end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_raw_default();
      test_load();
      test_ctrl_flush();
      test_store_rs2();
      test_random();
      test_halt_empty();
      test_halt_load();
      test_reset_mid_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hazard_orchestrator.md
# hazard_orchestrator

Parametrised successor to the core's stall/halt controller: a decode-stage hazard unit that tracks in-flight register writes and control-flow bubbles. It sits between IF/ID and the issue point. Per-register countdowns replace fixed previous/current instruction compares, so pipeline depth, load latency and control bubbles are set by parameter. Halting is a counted drain that also waits for the scoreboard to empty.

## Interface
- `INST_WIDTH_IN_BIT`, 32, instruction width; opcode/rd/rs1/rs2 at the RV32 bit positions.
- `WB_DEPTH`, 2, cycles after issue during which a written rd is unreadable (1..7).
- `LOAD_EXTRA`, 0, extra unreadable cycles added for LOAD results (0..7).
- `CTRL_BUBBLES`, 2, stall cycles after issuing BRANCH/JAL/JALR (0..7).
- `HALT_DRAIN`, 2, minimum drain cycles after the halt instruction issues (1..7).

Ports (clock and reset first):
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `inst_valid`  in  1  `next_inst` holds a real decoded instruction.
- `next_inst`  in  INST_WIDTH_IN_BIT  instruction requesting issue.
- `flush`  in  1  front-end redirect; cancels pending control bubbles and blocks issue this cycle.
- `issue`  out  1  `next_inst` is accepted this cycle.
- `stall_id_if_pl`  out  1  hold the IF/ID pipeline register.
- `stall_pc_increment`  out  1  hold the PC; always equal to `stall_id_if_pl`.
- `halt`  out  1  registered; core fully drained and stopped.
- `state`  out  2  FSM state for debug: 0 = RUN, 1 = DRAIN, 2 = HALTED.

## Operation
Instruction classes:
- **Reads rs1:** OP, OP_IMM, BRANCH, STORE, LOAD, JALR.
- **Reads rs2:** OP, BRANCH, STORE.
- **Writes rd:** OP, OP_IMM, LUI, AUIPC, JAL, JALR, LOAD. Writes to x0 are never tracked.

Scoreboard:
- `busy_cnt[r]`, r = 1..31, each `$clog2(WB_DEPTH+LOAD_EXTRA+1)` bits.
- On issue of an rd-writer, `busy_cnt[rd]` loads `WB_DEPTH`, or `WB_DEPTH+LOAD_EXTRA` for a LOAD.
- Every other nonzero counter decrements by 1 each cycle and saturates at 0.
- If a load and a decrement hit the same register in one cycle, the load wins.

Hazard and stall terms:
- `raw_hazard` = `inst_valid` AND (a used rs has a nonzero `busy_cnt`). Unused rs fields are ignored.
- `ctrl_cnt` loads `CTRL_BUBBLES` on issue of BRANCH/JAL/JALR. It decrements while nonzero. `flush` forces it to 0, and `flush` has priority over a load.
- `stall` = (state != RUN) OR (`ctrl_cnt` != 0) OR `raw_hazard`.
- `stall_id_if_pl` = `stall_pc_increment` = `stall`.
- `issue` = `inst_valid` AND NOT `stall` AND NOT `flush`.

FSM:
- **RUN → DRAIN:** on issue of `next_inst == 32'hC0001073` (the halt instruction). The halt instruction is never tracked as a writer. `drain_cnt` loads `HALT_DRAIN`.
- **DRAIN:** `drain_cnt` decrements each cycle. Move to HALTED in the cycle after `drain_cnt == 0` AND all `busy_cnt == 0`.
- **HALTED:** `halt` = 1. Sticky until reset.

The scoreboard keeps counting down in DRAIN and HALTED. `flush` in DRAIN or HALTED has no effect on the FSM.

## Timing
- Reset values:
  - all `busy_cnt`, `ctrl_cnt` and `drain_cnt` = 0;
  - state = RUN; `halt` = 0;
  - `issue` forced to 0 while `reset` is high.
- `stall`, `issue` and `stall_id_if_pl` are combinational from `next_inst`, `inst_valid`, `flush` and registered state. There is zero-cycle latency from instruction presentation to the stall decision.
- A dependent instruction presented in the cycle right after its producer issues stalls for exactly `WB_DEPTH` cycles (+`LOAD_EXTRA` for a load producer). It issues in the following cycle.
- A branch issued at cycle t stalls cycles t+1 .. t+CTRL_BUBBLES. `CTRL_BUBBLES = 0` means no stall.
- `halt` rises HALT_DRAIN+1 cycles after the halt instruction issues, provided the scoreboard is already empty. It rises later if a counter is still nonzero.
- Reset mid-DRAIN returns to RUN on the same edge with everything cleared.

## Structure
- Package `orchestrator_pkg` holds:
  - the `OPCODE_*` constants and `INVALID_INST`;
  - the state enum;
  - the functions `reads_rs1`, `reads_rs2` and `writes_rd` (each takes an opcode).
- Sub-module `hazard_scoreboard` holds the 31 countdown counters. It takes set port, rd, load-length, rs1 and rs2, and returns per-rs busy flags and `all_clear`.
- The top level owns `ctrl_cnt`, the FSM and the output logic.

## Test plan
1. Default parameters: `addi x5,x0,1`, then `add x6,x5,x5` next cycle → stall exactly 2 cycles; `add` issues on the third cycle.
2. `LOAD_EXTRA=2`: `lw x7,0(x1)`, then `addi x8,x7,1` → stall 4 cycles. The same sequence with rd=x0 → no stall.
3. `beq` issued at t with default parameters → stall at t+1 and t+2. Assert `flush` at t+1 → stall drops at t+1, `issue` stays 0 that cycle, and the next instruction issues at t+2.
4. `lui x3,...`, then `sw x9,0(x2)` (no x3 use) → no stall. A following `sw x3,0(x2)` → stall via rs2.
5. Halt instruction issued at t with an empty scoreboard, `HALT_DRAIN=2` → `halt` = 1 at t+3 and `stall` held throughout. Halt issued right after `lw` with `LOAD_EXTRA=5` → `halt` waits for the counter to reach zero.
6. Assert `reset` asynchronously mid-DRAIN with a busy counter → `state` = RUN, `halt` = 0 and `stall` = 0 immediately. The first post-reset `add` issues with no stall.
